down_timer: RTL and testbench

Loadable 4-bit (parameterisable) down-counter/timer with pause, terminal-count pulse and optional auto-reload. It is the down-counting counterpart to the synchronous up-counter. It is used wherever a block must wait a programmed number of enabled cycles, such as timeouts, baud dividers and pulse stretchers. A small FSM tracks idle, running, paused and expired states so consumers get clean `busy`/`done`/`tc` flags instead of decoding `q`.

---
 rtl/down_timer_pkg.sv | 10 +
 rtl/down_timer.sv | 67 ++++++
 tb/tb_down_timer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/down_timer_pkg.sv
// down_timer_pkg: state encoding and default width for the down_timer block.
package down_timer_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10,
    DONE = 2'b11
  } dt_state_t;
  localparam int DT_WIDTH_DEFAULT = 4;
endpackage

// File: rtl/down_timer.sv
// down_timer: loadable down-counter/timer with pause, terminal-count pulse and optional auto-reload.
module down_timer
  import down_timer_pkg::*;
#(
  parameter int WIDTH       = DT_WIDTH_DEFAULT,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             tc
);
  dt_state_t        r_state, w_state;
  logic [WIDTH-1:0] r_q, w_q, r_rld, w_rld;
  logic             r_tc, w_tc;
  logic             w_active;
  assign w_active = (r_state == RUN) || (r_state == HOLD);
  always_comb begin
    w_state = r_state;
    w_q     = r_q;
    w_rld   = r_rld;
    w_tc    = 1'b0;
    if (clr) begin
      w_state = IDLE;
      w_q     = '0;
    end else if (load) begin
      w_q     = load_val;
      w_rld   = load_val;
      w_state = (load_val == '0) ? IDLE : (en ? RUN : HOLD);
    end else if (w_active) begin
      if (!en) begin
        w_state = HOLD;
      end else if (r_q == WIDTH'(1)) begin
        // expiry: either restart from the last loaded value or park at zero
        w_tc    = 1'b1;
        w_q     = AUTO_RELOAD ? r_rld : '0;
        w_state = AUTO_RELOAD ? RUN : DONE;
      end else if (r_q > WIDTH'(1)) begin
        w_q     = r_q - WIDTH'(1);
        w_state = RUN;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_rld   <= '0;
      r_tc    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_q     <= w_q;
      r_rld   <= w_rld;
      r_tc    <= w_tc;
    end
  end
  assign q    = r_q;
  assign tc   = r_tc;
  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: one-shot and auto-reload timers driven side by side against a behavioural model.
module tb_down_timer;
  localparam int W = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_DONE = 3;
  logic         clk = 1'b0;
  logic         rst, clr, load, en;
  logic [W-1:0] load_val;
  logic [W-1:0] q0, q1;
  logic         busy0, busy1, done0, done1, tc0, tc1;
  int n_cmp = 0;
  int n_err = 0;
  int mq[2], mr[2], ms[2];
  bit mt[2];

  always #5 clk = ~clk;

  down_timer #(.WIDTH(W), .AUTO_RELOAD(1'b0)) u_one (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val), .en(en),
    .q(q0), .busy(busy0), .done(done0), .tc(tc0));
  down_timer #(.WIDTH(W), .AUTO_RELOAD(1'b1)) u_auto (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val), .en(en),
    .q(q1), .busy(busy1), .done(done1), .tc(tc1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < 2; a++) begin
      mq[a] = 0; mr[a] = 0; ms[a] = M_IDLE; mt[a] = 0;
    end
  endtask

  // Timer behaviour as described: clear beats load beats counting; counting only while armed.
  task automatic model_edge();
    for (int a = 0; a < 2; a++) begin
      mt[a] = 0;
      if (clr) begin
        mq[a] = 0; ms[a] = M_IDLE;
      end else if (load) begin
        mq[a] = int'(load_val); mr[a] = int'(load_val);
        ms[a] = (load_val == 0) ? M_IDLE : (en ? M_RUN : M_HOLD);
      end else if (ms[a] == M_RUN || ms[a] == M_HOLD) begin
        if (!en) ms[a] = M_HOLD;
        else if (mq[a] == 1) begin
          mt[a] = 1;
          if (a == 1) begin mq[a] = mr[a]; ms[a] = M_RUN; end
          else begin mq[a] = 0; ms[a] = M_DONE; end
        end else begin
          mq[a] = mq[a] - 1; ms[a] = M_RUN;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("q_one", q0, mq[0]);
    chk("busy_one", busy0, ms[0] == M_RUN);
    chk("done_one", done0, ms[0] == M_DONE);
    chk("tc_one", tc0, mt[0]);
    chk("q_auto", q1, mq[1]);
    chk("busy_auto", busy1, ms[1] == M_RUN);
    chk("done_auto", done1, ms[1] == M_DONE);
    chk("tc_auto", tc1, mt[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic c, input logic l, input int v, input logic e);
    clr = c; load = l; load_val = W'(v); en = e;
  endtask

  initial begin
    int n;
    drive(0, 0, 0, 0);
    rst = 1'b1;
    model_reset();
    #21 rst = 1'b0;
    #1 check_all();

    // basic countdown 5..0, then done persists
    drive(0, 1, 5, 1); tick();
    chk("load5_q", q0, 5);
    drive(0, 0, 0, 1);
    for (int i = 4; i >= 0; i--) begin
      tick();
      chk("cd_q", q0, i);
      chk("cd_tc", tc0, i == 0);
    end
    repeat (3) begin
      tick();
      chk("done_stay", done0, 1);
      chk("done_q0", q0, 0);
    end

    // pause: 3 counts, 4 idle cycles, expiry 13 edges after load
    drive(0, 1, 9, 1); tick();
    drive(0, 0, 0, 1); repeat (3) tick();
    drive(0, 0, 0, 0); repeat (4) tick();
    chk("pause_q", q0, 6);
    chk("pause_busy", busy0, 0);
    drive(0, 0, 0, 1);
    n = 7;
    while (!tc0 && n < 60) begin tick(); n++; end
    chk("pause_lat", n, 13);

    // auto-reload with 3: tc every third edge, never done
    drive(0, 1, 3, 1); tick();
    drive(0, 0, 0, 1);
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk("ar_q", q1, 3 - (i % 3));
      chk("ar_tc", tc1, (i % 3) == 0);
      chk("ar_done", done1, 0);
    end

    // load zero, then load colliding with expiry
    drive(0, 1, 0, 1); tick();
    chk("ld0_tc", tc0, 0);
    chk("ld0_busy", busy0, 0);
    drive(0, 1, 2, 1); tick();
    drive(0, 0, 0, 1); tick();
    drive(0, 1, 7, 1); tick();
    chk("ldexp_tc", tc0, 0);
    chk("ldexp_q", q0, 7);

    // full range, no wrap
    drive(0, 1, 15, 1); tick();
    drive(0, 0, 0, 1);
    repeat (15) tick();
    chk("full_q", q0, 0);
    chk("full_tc", tc0, 1);
    tick();
    chk("full_nowrap", q0, 0);

    // clear while paused
    drive(0, 1, 9, 0); tick();
    drive(1, 0, 0, 0); tick();
    chk("clr_q", q0, 0);
    chk("clr_busy", busy0, 0);
    drive(0, 0, 0, 1); tick();

    // asynchronous reset mid-count
    drive(0, 1, 12, 1); tick();
    drive(0, 0, 0, 1); repeat (3) tick();
    rst = 1'b1;
    #2;
    model_reset();
    chk("rst_q_async", q0, 0);
    check_all();
    #18 rst = 1'b0;
    repeat (3) begin
      tick();
      chk("rst_stay", q1, 0);
    end

    // randomized traffic
    repeat (600) begin
      drive($urandom_range(31) == 0, $urandom_range(7) == 0, $urandom_range(15),
            $urandom_range(3) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
